baby_word_serialiser: RTL and testbench

//   Parallel-to-serial word transmitter for the Baby store/accumulator serial lines.

---
 rtl/baby_word_serialiser_if.sv | 32 +++
 rtl/baby_word_serialiser.sv | 103 ++++++++++
 tb/tb_baby_word_serialiser.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/baby_word_serialiser_if.sv
// Handshake/bus bundle for baby_word_serialiser.
//   master : drives load/word_in, observes the serial line and status
//   slave  : the serialiser itself
// Signals:
//   load        request to transmit word_in
//   word_in     parallel word, captured when load is accepted
//   busy        word in flight
//   serial_out  current bit, LSB first, 0 when not busy
//   bit_strobe  first clock of every bit period
//   word_sync   whole of bit 0's period
//   done        one-clock pulse after the final bit period
interface baby_word_serialiser_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  load;
    logic [WORD_WIDTH-1:0] word_in;
    logic                  busy;
    logic                  serial_out;
    logic                  bit_strobe;
    logic                  word_sync;
    logic                  done;

    modport master (
        output load, word_in,
        input  busy, serial_out, bit_strobe, word_sync, done
    );

    modport slave (
        input  load, word_in,
        output busy, serial_out, bit_strobe, word_sync, done
    );
endinterface

// File: rtl/baby_word_serialiser.sv
// Parallel-to-serial word transmitter for the Baby store/accumulator lines.
// A word accepted on load is shifted out LSB first, each bit held for
// BIT_PERIOD clocks; word_sync marks bit 0 and done pulses for one clock
// after the last bit. A load arriving on the done clock starts the next
// word immediately, so a held load streams words with a one-clock gap.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any word in flight
//   bus    baby_word_serialiser_if.slave (load, word_in, busy, serial_out,
//          bit_strobe, word_sync, done)
// All outputs are decoded directly from flops, so they follow reset
// without waiting for a clock edge.
module baby_word_serialiser #(
    parameter int WORD_WIDTH        = 32,
    parameter int BIT_PERIOD        = 4,
    parameter int PROPAGATION_DELAY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    baby_word_serialiser_if.slave bus
);
    localparam int BCNT_W = $clog2(WORD_WIDTH);
    localparam int PCNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT    = BCNT_W'(WORD_WIDTH - 1);
    localparam logic [PCNT_W-1:0] LAST_PERIOD = PCNT_W'(BIT_PERIOD - 1);

    // Output delay is a gate-level timing figure only; the synthesised
    // block has no delay element to configure.
    if (PROPAGATION_DELAY > 0) begin : g_gate_level_delay_only
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCNT_W-1:0]     bcnt_q,  bcnt_d;
    logic [PCNT_W-1:0]     pcnt_q,  pcnt_d;

    logic last_period;
    logic last_bit;

    assign last_period = (pcnt_q == LAST_PERIOD);
    assign last_bit    = (bcnt_q == LAST_BIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a load too, giving back-to-back words.
                if (bus.load) begin
                    state_d = SHIFT;
                    shreg_d = bus.word_in;
                    bcnt_d  = '0;
                    pcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // load is deliberately not looked at here.
                if (last_period) begin
                    pcnt_d = '0;
                    if (last_bit) begin
                        // Bit counter only ever wraps through DONE.
                        state_d = DONE;
                        bcnt_d  = '0;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bcnt_d  = bcnt_q + BCNT_W'(1);
                    end
                end else begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q == SHIFT);
    assign bus.serial_out = (state_q == SHIFT) && shreg_q[0];
    assign bus.bit_strobe = (state_q == SHIFT) && (pcnt_q == '0);
    assign bus.word_sync  = (state_q == SHIFT) && (bcnt_q == '0);
    assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_baby_word_serialiser.sv
// Bench for baby_word_serialiser. Two instances run side by side:
//   unit 0: WORD_WIDTH=32, BIT_PERIOD=4
//   unit 1: WORD_WIDTH=8,  BIT_PERIOD=1
// The driver decides from word timing alone whether a load is taken, and
// on acceptance queues the full expected per-clock picture of the word
// (bit value, strobe, sync) followed by a done record. The monitor pops
// one record for every clock the DUT shows busy or done.
module tb_baby_word_serialiser;
    localparam int WW_A = 32;
    localparam int BP_A = 4;
    localparam int WW_B = 8;
    localparam int BP_B = 1;

    typedef struct packed {
        logic ser;
        logic stb;
        logic sync;
        logic dn;
    } rec_t;

    logic clk = 1'b0;
    logic reset;

    baby_word_serialiser_if #(.WORD_WIDTH(WW_A)) if_a ();
    baby_word_serialiser_if #(.WORD_WIDTH(WW_B)) if_b ();

    baby_word_serialiser #(.WORD_WIDTH(WW_A), .BIT_PERIOD(BP_A), .PROPAGATION_DELAY(0)) u_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );
    baby_word_serialiser #(.WORD_WIDTH(WW_B), .BIT_PERIOD(BP_B), .PROPAGATION_DELAY(0)) u_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[2][$];
    int   next_free[2];
    int   edge_n = 0;

    task automatic fail(string name, string msg);
        errors++;
        $display("FAIL %s unit-check: %s", name, msg);
    endtask

    // Reference: a word is WW bits, each held BP clocks, then one done clock.
    task automatic push_word(int u, logic [31:0] w);
        int ww, bp;
        rec_t r;
        ww = (u == 0) ? WW_A : WW_B;
        bp = (u == 0) ? BP_A : BP_B;
        for (int i = 0; i < ww; i++)
            for (int p = 0; p < bp; p++) begin
                r = '{ser: w[i], stb: (p == 0), sync: (i == 0), dn: 1'b0};
                exp_q[u].push_back(r);
            end
        r = '{ser: 1'b0, stb: 1'b0, sync: 1'b0, dn: 1'b1};
        exp_q[u].push_back(r);
        next_free[u] = edge_n + ww * bp + 1;
    endtask

    // One rising edge; any load the model considers free is accepted.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (!reset) begin
            if (if_a.load && edge_n >= next_free[0]) push_word(0, if_a.word_in);
            if (if_b.load && edge_n >= next_free[1]) push_word(1, {24'h0, if_b.word_in});
        end
        #1;
    endtask

    task automatic check_cycle(int u, logic b, logic s, logic st, logic sy, logic d);
        rec_t r;
        checks++;
        if (!b && !d) begin
            if (s || st || sy)
                fail("idle_outputs", $sformatf("u%0d ser=%b stb=%b sync=%b want all 0", u, s, st, sy));
            else if (exp_q[u].size() != 0)
                fail("missing_output", $sformatf("u%0d idle but %0d records pending", u, exp_q[u].size()));
            return;
        end
        if (exp_q[u].size() == 0) begin
            fail("unexpected_output", $sformatf("u%0d busy=%b done=%b with nothing expected", u, b, d));
            return;
        end
        r = exp_q[u].pop_front();
        if ({b, d, s, st, sy} !== {~r.dn, r.dn, r.ser, r.stb, r.sync})
            fail("serial_cycle", $sformatf("u%0d got busy/done/ser/stb/sync=%b%b%b%b%b want %b%b%b%b%b",
                 u, b, d, s, st, sy, ~r.dn, r.dn, r.ser, r.stb, r.sync));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check_cycle(0, if_a.busy, if_a.serial_out, if_a.bit_strobe, if_a.word_sync, if_a.done);
            check_cycle(1, if_b.busy, if_b.serial_out, if_b.bit_strobe, if_b.word_sync, if_b.done);
        end
    end

    task automatic check_reset_outputs();
        checks++;
        if ({if_a.busy, if_a.serial_out, if_a.bit_strobe, if_a.word_sync, if_a.done} !== 5'b0)
            fail("reset_outputs_a", $sformatf("got %b%b%b%b%b want 00000", if_a.busy, if_a.serial_out,
                 if_a.bit_strobe, if_a.word_sync, if_a.done));
        checks++;
        if ({if_b.busy, if_b.serial_out, if_b.bit_strobe, if_b.word_sync, if_b.done} !== 5'b0)
            fail("reset_outputs_b", $sformatf("got %b%b%b%b%b want 00000", if_b.busy, if_b.serial_out,
                 if_b.bit_strobe, if_b.word_sync, if_b.done));
    endtask

    // Reset pulse in the low half of the clock; no edge occurs while it is high.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        next_free[0] = 0;
        next_free[1] = 0;
        #1;
        check_reset_outputs();
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        if_a.load = 1'b0;
        if_b.load = 1'b0;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0)
            fail("drain_timeout", $sformatf("pending a=%0d b=%0d want 0 0", exp_q[0].size(), exp_q[1].size()));
        tick();
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        if_a.load    = 1'b0;
        if_a.word_in = '0;
        if_b.load    = 1'b0;
        if_b.word_in = '0;
        next_free[0] = 0;
        next_free[1] = 0;

        pulse_reset();
        tick();

        // LSB-first word on A, 8'h96 at one bit per clock on B.
        if_a.load = 1'b1; if_a.word_in = 32'hA5A5_0001;
        if_b.load = 1'b1; if_b.word_in = 8'h96;
        tick();
        drain();

        // Second load mid-word is ignored.
        if_a.load = 1'b1; if_a.word_in = 32'hFFFF_FFFF;
        tick();
        if_a.load = 1'b0;
        repeat (19) tick();
        if_a.load = 1'b1; if_a.word_in = 32'h0;
        tick();
        drain();

        // Held load: next word presented on the done clock.
        if_a.load = 1'b1; if_a.word_in = 32'h8000_0001;
        tick();
        while (edge_n < next_free[0] - 1) tick();
        if_a.word_in = 32'h0000_0003;
        tick();
        drain();

        // Reset mid-word aborts it; next word starts clean.
        if_a.load = 1'b1; if_a.word_in = 32'hDEAD_BEEF;
        if_b.load = 1'b1; if_b.word_in = 8'h5A;
        tick();
        if_a.load = 1'b0;
        if_b.load = 1'b0;
        repeat (50) tick();
        pulse_reset();
        if_a.load = 1'b1; if_a.word_in = 32'h1234_5679;
        if_b.load = 1'b1; if_b.word_in = 8'hC3;
        tick();
        drain();

        // Random load traffic on both units.
        for (int c = 0; c < 2500; c++) begin
            if_a.load    = ($urandom_range(0, 7) < 3);
            if_a.word_in = $urandom;
            if_b.load    = ($urandom_range(0, 7) < 4);
            if_b.word_in = 8'($urandom);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
